// File: rtl/adder_tree_var_pipe_if.sv
// Lane/handshake bundle for the pipelined adder tree.
// The master drives the lanes and pipe control. The slave returns the reduced sum.
interface adder_tree_var_pipe_if #(
    parameter int DATA_WIDTH = 16,
    parameter int NUM_IN     = 8
);
    localparam int LEVELS = $clog2(NUM_IN);

    logic [NUM_IN*DATA_WIDTH-1:0] i_data;
    logic [NUM_IN-1:0]            i_valid;
    logic                         i_mode;
    logic                         i_en;
    logic                         i_flush;
    logic [DATA_WIDTH+LEVELS-1:0] o_data;
    logic                         o_valid;
    logic [LEVELS:0]              o_cnt;

    modport master (
        output i_data, i_valid, i_mode, i_en, i_flush,
        input  o_data, o_valid, o_cnt
    );

    modport slave (
        input  i_data, i_valid, i_mode, i_en, i_flush,
        output o_data, o_valid, o_cnt
    );
endinterface

// File: rtl/adder_tree_var_pipe.sv
// Fully pipelined NUM_IN-to-1 adder tree with one register level per tree level.
// Supports strict or masked lane qualification, stall-and-hold on i_en, and a synchronous flush.
module adder_tree_var_pipe #(
    parameter int DATA_WIDTH = 16,
    parameter int NUM_IN     = 8,
    parameter int SIGNED     = 1
) (
    input logic                  clk,
    input logic                  rst_n,
    adder_tree_var_pipe_if.slave bus
);
    localparam int LEVELS = $clog2(NUM_IN);
    localparam logic EXT_SIGN = (SIGNED != 0);

    function automatic logic [LEVELS:0] popcount(input logic [NUM_IN-1:0] v);
        logic [LEVELS:0] c;
        c = '0;
        for (int k = 0; k < NUM_IN; k++) begin
            c = c + (LEVELS+1)'(v[k]);
        end
        return c;
    endfunction

    logic issue_vld_p0;
    logic en_d;

    always_comb begin
        issue_vld_p0 = bus.i_mode ? (|bus.i_valid) : (&bus.i_valid);
    end

    // In masked mode, invalid lanes enter as zero. A bubble forces every lane to zero.
    genvar l;
    generate
        for (l = 0; l <= LEVELS; l++) begin : g_lvl
            localparam int W = DATA_WIDTH + l;
            localparam int N = NUM_IN >> l;

            logic [W-1:0]    sum [N];
            logic            vld;
            logic [LEVELS:0] cnt;

            if (l == 0) begin : g_in
                // ---- stage p0: gated input lanes (combinational) ----
                always_comb begin
                    for (int k = 0; k < N; k++) begin
                        sum[k] = (issue_vld_p0 && (!bus.i_mode || bus.i_valid[k]))
                               ? bus.i_data[k*DATA_WIDTH +: DATA_WIDTH] : '0;
                    end
                    vld = issue_vld_p0;
                    if (!issue_vld_p0)
                        cnt = '0;
                    else if (bus.i_mode)
                        cnt = popcount(bus.i_valid);
                    else
                        cnt = (LEVELS+1)'(NUM_IN);
                end
            end else begin : g_add
                logic [W-1:0] a_ext [N];
                logic [W-1:0] b_ext [N];

                // One guard bit per level means the pair sum can never overflow.
                always_comb begin
                    for (int k = 0; k < N; k++) begin
                        a_ext[k] = {EXT_SIGN & g_lvl[l-1].sum[2*k][W-2],   g_lvl[l-1].sum[2*k]};
                        b_ext[k] = {EXT_SIGN & g_lvl[l-1].sum[2*k+1][W-2], g_lvl[l-1].sum[2*k+1]};
                    end
                end

                // ---- stage p(l): pairwise sums registered at this tree level ----
                always_ff @(posedge clk or negedge rst_n) begin
                    if (!rst_n) begin
                        for (int k = 0; k < N; k++) sum[k] <= '0;
                        vld <= 1'b0;
                        cnt <= '0;
                    end else if (bus.i_flush) begin
                        for (int k = 0; k < N; k++) sum[k] <= '0;
                        vld <= 1'b0;
                        cnt <= '0;
                    end else if (bus.i_en) begin
                        for (int k = 0; k < N; k++) sum[k] <= a_ext[k] + b_ext[k];
                        vld <= g_lvl[l-1].vld;
                        cnt <= g_lvl[l-1].cnt;
                    end
                end
            end
        end
    endgenerate

    // en_d qualifies o_valid so that a held result is presented only once.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            en_d <= 1'b0;
        else if (bus.i_flush)
            en_d <= 1'b0;
        else
            en_d <= bus.i_en;
    end

    assign bus.o_data  = g_lvl[LEVELS].sum[0];
    assign bus.o_cnt   = g_lvl[LEVELS].cnt;
    assign bus.o_valid = g_lvl[LEVELS].vld & en_d;
endmodule

// File: tb/tb_adder_tree_var_pipe.sv
// Directed bench for adder_tree_var_pipe. It uses a signed and an unsigned 8-lane instance driven in parallel.
module tb_adder_tree_var_pipe;
    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic         rst_n;
    logic [127:0] d;
    logic [7:0]   v;
    logic         m, en, fl;

    adder_tree_var_pipe_if #(.DATA_WIDTH(16), .NUM_IN(8)) bus_s ();
    adder_tree_var_pipe_if #(.DATA_WIDTH(16), .NUM_IN(8)) bus_u ();

    assign bus_s.i_data  = d;
    assign bus_s.i_valid = v;
    assign bus_s.i_mode  = m;
    assign bus_s.i_en    = en;
    assign bus_s.i_flush = fl;
    assign bus_u.i_data  = d;
    assign bus_u.i_valid = v;
    assign bus_u.i_mode  = m;
    assign bus_u.i_en    = en;
    assign bus_u.i_flush = fl;

    adder_tree_var_pipe #(.DATA_WIDTH(16), .NUM_IN(8), .SIGNED(1)) dut_s (
        .clk(clk), .rst_n(rst_n), .bus(bus_s)
    );
    adder_tree_var_pipe #(.DATA_WIDTH(16), .NUM_IN(8), .SIGNED(0)) dut_u (
        .clk(clk), .rst_n(rst_n), .bus(bus_u)
    );

    typedef struct {
        string        name;
        logic [127:0] data;
        logic [7:0]   valid;
        logic         mode;
        int           ev;
        int           es;
        int           eu;
        int           ec;
    } vec_t;

    vec_t tbl [10];
    int   n_vec = 0;
    int   n_err = 0;
    int   edge_no = 0;
    int   q_data [$];
    int   q_edge [$];

    task automatic chk(input string name, input int act, input int exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0d (0x%0h), expected %0d (0x%0h)", name, act, act, exp, exp);
        end
    endtask

    task automatic step(input logic [127:0] sd, input logic [7:0] sv, input logic sm,
                        input logic sen, input logic sfl);
        d = sd; v = sv; m = sm; en = sen; fl = sfl;
        @(posedge clk);
        edge_no++;
        #1;
        if (bus_s.o_valid === 1'b1) begin
            q_data.push_back(int'(bus_s.o_data));
            q_edge.push_back(edge_no);
        end
    endtask

    task automatic idle();
        step('0, 8'h00, 1'b0, 1'b1, 1'b0);
    endtask

    function automatic int q_at_data(input int i);
        return (q_data.size() > i) ? q_data[i] : -1;
    endfunction

    function automatic int q_at_edge(input int i);
        return (q_edge.size() > i) ? q_edge[i] : -1;
    endfunction

    initial begin
        int exp_d [5];
        int exp_e [5];
        exp_d = '{10, 20, 30, 40, 50};
        exp_e = '{3, 6, 7, 8, 9};

        tbl[0] = '{"strict_1to8",   128'h0008_0007_0006_0005_0004_0003_0002_0001, 8'hFF, 1'b0, 1, 36,        36,        8};
        tbl[1] = '{"all_8000",      {8{16'h8000}},                                 8'hFF, 1'b0, 1, 'h40000,   'h40000,   8};
        tbl[2] = '{"all_7fff",      {8{16'h7FFF}},                                 8'hFF, 1'b0, 1, 'h3FFF8,   'h3FFF8,   8};
        tbl[3] = '{"all_ffff",      {8{16'hFFFF}},                                 8'hFF, 1'b0, 1, 'h7FFF8,   'h7FFF8,   8};
        tbl[4] = '{"lane0_ffff",    128'h0000_0000_0000_0000_0000_0000_0000_FFFF, 8'hFF, 1'b0, 1, 'h7FFFF,   'h0FFFF,   8};
        tbl[5] = '{"masked_05",     128'h0064_0064_0064_0064_0064_FFFD_0064_000A, 8'h05, 1'b1, 1, 7,         'h10007,   2};
        tbl[6] = '{"strict_05",     128'h0064_0064_0064_0064_0064_FFFD_0064_000A, 8'h05, 1'b0, 0, 0,         0,         0};
        tbl[7] = '{"masked_none",   128'h0064_0064_0064_0064_0064_FFFD_0064_000A, 8'h00, 1'b1, 0, 0,         0,         0};
        tbl[8] = '{"masked_lane7",  128'h0005_0064_0064_0064_0064_0064_0064_0064, 8'h80, 1'b1, 1, 5,         5,         1};
        tbl[9] = '{"masked_all",    128'h0008_0007_0006_0005_0004_0003_0002_0001, 8'hFF, 1'b1, 1, 36,        36,        8};

        rst_n = 1'b0;
        d = '0; v = '0; m = 1'b0; en = 1'b1; fl = 1'b0;
        #12;
        chk("reset_o_valid", int'(bus_s.o_valid), 0);
        chk("reset_o_data",  int'(bus_s.o_data),  0);
        chk("reset_o_cnt",   int'(bus_s.o_cnt),   0);
        @(negedge clk);
        rst_n = 1'b1;
        idle();

        for (int i = 0; i < 10; i++) begin
            step(tbl[i].data, tbl[i].valid, tbl[i].mode, 1'b1, 1'b0);
            chk({tbl[i].name, "_early1"}, int'(bus_s.o_valid), 0);
            idle();
            chk({tbl[i].name, "_early2"}, int'(bus_s.o_valid), 0);
            idle();
            chk({tbl[i].name, "_valid"},  int'(bus_s.o_valid), tbl[i].ev);
            chk({tbl[i].name, "_data_s"}, int'(bus_s.o_data),  tbl[i].es);
            chk({tbl[i].name, "_cnt"},    int'(bus_s.o_cnt),   tbl[i].ec);
            chk({tbl[i].name, "_data_u"}, int'(bus_u.o_data),  tbl[i].eu);
            chk({tbl[i].name, "_valid_u"}, int'(bus_u.o_valid), tbl[i].ev);
            idle();
            chk({tbl[i].name, "_after"},  int'(bus_s.o_valid), 0);
        end

        // Stream five vectors with a two-cycle stall after the third issue.
        q_data.delete(); q_edge.delete(); edge_no = 0;
        step(128'(10), 8'hFF, 1'b0, 1'b1, 1'b0);
        step(128'(20), 8'hFF, 1'b0, 1'b1, 1'b0);
        step(128'(30), 8'hFF, 1'b0, 1'b1, 1'b0);
        step(128'(99), 8'hFF, 1'b0, 1'b0, 1'b0);
        step(128'(99), 8'hFF, 1'b0, 1'b0, 1'b0);
        step(128'(40), 8'hFF, 1'b0, 1'b1, 1'b0);
        step(128'(50), 8'hFF, 1'b0, 1'b1, 1'b0);
        for (int i = 0; i < 7; i++) idle();
        chk("stream_count", q_data.size(), 5);
        for (int i = 0; i < 5; i++) begin
            chk($sformatf("stream_data%0d", i), q_at_data(i), exp_d[i]);
            chk($sformatf("stream_edge%0d", i), q_at_edge(i), exp_e[i]);
        end

        // Flush with two items in flight, then issue right after the flush edge.
        q_data.delete(); q_edge.delete(); edge_no = 0;
        step(128'(11), 8'hFF, 1'b0, 1'b1, 1'b0);
        step(128'(22), 8'hFF, 1'b0, 1'b1, 1'b0);
        step(128'(33), 8'hFF, 1'b0, 1'b0, 1'b1);
        chk("flush_no_valid", int'(bus_s.o_valid), 0);
        step(128'(44), 8'hFF, 1'b0, 1'b1, 1'b0);
        for (int i = 0; i < 6; i++) idle();
        chk("flush_count", q_data.size(), 1);
        chk("flush_data",  q_at_data(0), 44);
        chk("flush_edge",  q_at_edge(0), 6);

        // Asynchronous reset in the middle of a stream.
        q_data.delete(); q_edge.delete(); edge_no = 0;
        step(128'(7), 8'hFF, 1'b0, 1'b1, 1'b0);
        step(128'(8), 8'hFF, 1'b0, 1'b1, 1'b0);
        step(128'(9), 8'hFF, 1'b0, 1'b1, 1'b0);
        chk("prereset_valid", int'(bus_s.o_valid), 1);
        chk("prereset_data",  int'(bus_s.o_data),  7);
        #2;
        rst_n = 1'b0;
        #1;
        chk("areset_valid", int'(bus_s.o_valid), 0);
        chk("areset_data",  int'(bus_s.o_data),  0);
        chk("areset_cnt",   int'(bus_s.o_cnt),   0);
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        q_data.delete(); q_edge.delete();
        for (int i = 0; i < 6; i++) idle();
        chk("postreset_no_stale", q_data.size(), 0);
        step(128'h0000_0000_0000_0000_0000_0000_0003_0002, 8'hFF, 1'b0, 1'b1, 1'b0);
        idle();
        idle();
        chk("postreset_valid", int'(bus_s.o_valid), 1);
        chk("postreset_data",  int'(bus_s.o_data),  5);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule

// File: doc/adder_tree_var_pipe.md
Name: adder_tree_var_pipe

Overview:
Parametrised, fully pipelined signed/unsigned adder tree that reduces NUM_IN lanes of DATA_WIDTH data to one sum, with one register level per tree level.
It supports two lane-qualification modes: strict (all lanes valid) and masked (invalid lanes contribute zero).
Pipeline control is stall-and-hold on i_en plus a synchronous flush.
It sits between PE-row outputs and the accumulation/writeback stage of the systolic array, replacing chains of two-input sequential adders.

Parameters:
DATA_WIDTH, 16, width of each input lane.
NUM_IN, 8, number of input lanes; power of two, >= 2.
SIGNED, 1, 1 = two's-complement sign extension at each level; 0 = zero extension.
LEVELS (derived localparam), log2(NUM_IN), tree depth = pipeline latency.

Ports:
clk  input  1  clock.
rst_n  input  1  reset.
i_data  input  NUM_IN*DATA_WIDTH  lane k at [k*DATA_WIDTH +: DATA_WIDTH].
i_valid  input  NUM_IN  per-lane valid.
i_mode  input  1  0 = strict, 1 = masked.
i_en  input  1  pipeline advance enable; 0 = stall.
i_flush  input  1  synchronous clear of all in-flight data.
o_data  output  DATA_WIDTH+LEVELS  sum.
o_valid  output  1  o_data valid; high for exactly one cycle per result.
o_cnt  output  LEVELS+1  number of lanes that contributed to o_data.

Behaviour:
- Reset: rst_n asynchronous, active-low; clock clk, rising edge.
  - While reset is asserted, all stage data, valid and count registers are 0, and en_d = 0.
  - Therefore o_data = 0, o_valid = 0, o_cnt = 0 immediately on assertion, including mid-operation; all in-flight items are lost.
- Issue at each rising edge with i_en = 1 and i_flush = 0:
  - Strict mode: issue valid = &i_valid. All lanes are used; cnt = NUM_IN.
  - Masked mode: lane k contributes i_data lane k if i_valid[k], else 0. Issue valid = |i_valid; cnt = popcount(i_valid).
  - No issue valid: a bubble enters the pipe, with data forced to all-zero and cnt = 0.
- Tree structure:
  - Level l (1..LEVELS) registers NUM_IN>>l partial sums of width DATA_WIDTH+l, plus one valid bit and one count.
  - Each level adds adjacent pairs from level l-1 (level 0 = gated input lanes), each operand extended by 1 bit per SIGNED.
  - Width growth makes overflow impossible.
- Latency: exactly LEVELS enabled edges from issue to result.
  - Level LEVELS registers drive o_data and o_cnt directly.
  - Throughput: one vector per enabled cycle.
- Stall (i_en = 0 at an edge, i_flush = 0): every stage register holds its value; the input is not sampled.
- en_d: register of i_en at each edge; reset 0; set to 0 by flush.
- o_valid = v[LEVELS] AND en_d. A result is presented for exactly one cycle after the edge that moved it into the last level. It is not re-presented during stall cycles, while o_data and o_cnt stay held.
- Flush (i_flush = 1 at an edge):
  - Overrides i_en.
  - Clears all valid bits, data and counts to 0 and sets en_d = 0.
  - Input on that edge is discarded.
  - o_valid = 0 in the following cycle; normal issue resumes at the next edge with i_flush = 0.
- Simultaneous events:
  - Flush and stall at the same edge: flush wins.
  - Reset dominates everything.
  - i_mode is sampled per issue edge, so mode changes take effect per vector with no drain needed.
- Bubbles never produce o_valid; o_data for a bubble result is 0.

Test Plan:
(All with NUM_IN=8, DATA_WIDTH=16, LEVELS=3, o_data 19 bits.)
1. Strict, i_valid=8'hFF, lanes 1..8, single issue -> 3 edges later o_valid=1 for one cycle, o_data=36, o_cnt=8; o_valid=0 before and after.
2. SIGNED=1:
   - All lanes 16'h8000 -> o_data=19'h40000 (-262144).
   - All lanes 16'h7FFF -> 19'h3FFF8.
   - SIGNED=0, all lanes 16'hFFFF -> 19'h7FFF8.
3. i_valid=8'b0000_0101, lane0=10, lane2=-3, other lanes 100:
   - Masked -> o_data=7, o_cnt=2.
   - Strict, same vector -> no o_valid at all.
   - Masked with i_valid=0 -> no o_valid.
4. Stream 5 vectors (sums 10,20,30,40,50) on consecutive edges, i_en low for 2 cycles after the 3rd issue -> exactly 5 o_valid pulses, in order 10..50, no duplicates during the stall, last result 2 cycles later than unstalled.
5. Two items in flight, then i_flush=1 for one edge -> neither result emerges; a vector issued the edge after flush returns correctly 3 edges later.
6. rst_n pulsed low asynchronously mid-stream -> o_valid/o_data/o_cnt go to 0 without a clock edge; no pre-reset item appears after release.
